vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Pixel-generation stage directly downstream of the VGA sync/counter generator in the 25 MHz video path. It consumes the raw beam position, display-enable and sync signals and produces a registered 6-bit colour (2 bits per channel, 64 colours) with sync outputs delayed to match. It supports four test patterns, selectable at run time, and an 8-bit frame counter for animation. Pattern changes take effect only on frame boundaries, so there is no mid-frame tearing.

## Interface
- `H_ACTIVE`, default 640: active pixels per line; used only for the range check in the bench.
- `V_ACTIVE`, default 480: active lines per frame; used only for the range check in the bench.
- `clk_25`  in  1  pixel clock, 25 MHz; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `counter_x`  in  10  horizontal beam position from the sync generator.
- `counter_y`  in  10  vertical beam position from the sync generator.
- `in_display_area`  in  1  high while the beam is in the visible region.
- `hsync_in`  in  1  horizontal sync from the generator, active-low.
- `vsync_in`  in  1  vertical sync from the generator, active-low.
- `mode_next`  in  1  single-cycle pulse requesting a switch to the next pattern; already synchronous to `clk_25`.
- `pixel_out`  out  6  colour `{R[1:0],G[1:0],B[1:0]}`, registered.
- `hsync_out`  out  1  `hsync_in` delayed 2 cycles.
- `vsync_out`  out  1  `vsync_in` delayed 2 cycles.
- `mode`  out  2  currently applied pattern.

## Operation
- Pipeline stage 1 registers these inputs into s1: `counter_x`, `counter_y`, `in_display_area`, `hsync_in`, `vsync_in`.
- Pipeline stage 2 computes the colour from the s1 values, `mode` and `frame_count`, then registers `pixel_out`, `hsync_out` and `vsync_out`.
- Frame edge: the cycle in which `vsync_in` is 0 and the registered `vsync_prev` is 1 (falling edge of the raw input).
- `frame_count` (8-bit, internal):
  - increments by 1 on each frame edge;
  - wraps 255 -> 0.
- Mode request handling:
  - `pending` is set by `mode_next`.
  - On a frame edge where `pending` is 1, `mode` advances by 1 (wrapping 3 -> 0) and `pending` clears.
  - Several `mode_next` pulses within one frame collapse to a single advance.
  - If `mode_next` arrives in the same cycle as a frame edge, the edge acts on the old `pending` value. The new pulse leaves `pending` = 1 for the following frame.
- Colour selection, evaluated only when s1 `in_display_area` = 1 (x and y below are the s1 `counter_x` and `counter_y`):
  - mode 0, palette grid: `{y[8:6], x[8:6]}`.
  - mode 1, scrolling gradient: `x[9:4] + frame_count[5:0]`, truncated to 6 bits.
  - mode 2, checkerboard: 6'h3F if `x[5] ^ y[5] ^ frame_count[6]`, else 6'h00.
  - mode 3, solid white: 6'h3F.
- When s1 `in_display_area` = 0, `pixel_out` is 6'h00 regardless of mode.
- `mode` and `frame_count` are read as registered values. An update on a frame edge is visible to pixels entering stage 2 from the next cycle onward.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - `pixel_out` = 0, `hsync_out` = 1, `vsync_out` = 1, `mode` = 0;
  - `frame_count` = 0, `pending` = 0;
  - all s1 registers cleared, with syncs cleared to 1;
  - `vsync_prev` = 1, so the first frame edge after reset counts.
- Reset release: outputs are valid 2 cycles after the first rising edge with `rst_n` = 1.
- Reset asserted mid-frame: outputs return to reset values immediately, without waiting for a clock. A `pending` request is discarded.
- Latency from input to output is exactly 2 cycles for pixel, hsync and vsync. They stay mutually aligned at all times, including across mode changes.
- Throughput is one pixel per cycle, with no stalls and no backpressure.
- `mode` changes only in the cycle after a frame edge, never during active video.

## Test plan
- Reset:
  - stimulus: assert `rst_n` = 0 while driving active video with white pixels;
  - required response: within the same cycle, `pixel_out` = 0, `hsync_out` = `vsync_out` = 1 and `mode` = 0; after release, the first valid pixel appears 2 cycles later.
- Pipeline alignment:
  - stimulus: drive a full 800x525 frame from a model sync generator;
  - required response: `hsync_out` and `vsync_out` equal the inputs delayed by exactly 2 cycles; `pixel_out` = 0 whenever the display-enable delayed by 2 cycles is 0.
- Mode 0 pattern:
  - stimulus: x = 200, y = 130, display enabled;
  - required response: 2 cycles later `pixel_out` = 6'b010_011.
- Mode advance at frame boundary:
  - stimulus: pulse `mode_next` 3 times mid-frame;
  - required response: `mode` stays 0 until the next `vsync_in` falling edge, then becomes 1 (not 3).
  - stimulus: pulse `mode_next` in the exact cycle of a frame edge;
  - required response: `mode` advances only on the following edge.
- Scroll and wrap:
  - stimulus: in mode 1 after 70 frame edges, with x = 16;
  - required response: `pixel_out` = (1 + 70) mod 64 = 7.
  - stimulus: run 256 frame edges;
  - required response: `frame_count` returns to 0 and the mode 2 checkerboard phase follows `frame_count[6]`.
- Mode wrap:
  - stimulus: four single requests spread across four frames;
  - required response: `mode` sequence is 1, 2, 3, 0; in mode 3 every active pixel is 6'h3F.

Source files
------------

// File: rtl/vga_pattern_if.sv
// Video pixel-stage bundle: raw beam position and syncs from the sync generator
// toward the pattern stage, plus the coloured, re-timed stream coming back out.
interface vga_pattern_if;
   logic [9:0] counter_x;
   logic [9:0] counter_y;
   logic       in_display_area;
   logic       hsync_in;
   logic       vsync_in;
   logic       mode_next;
   logic [5:0] pixel_out;
   logic       hsync_out;
   logic       vsync_out;
   logic [1:0] mode;

   modport master (
      output counter_x, counter_y, in_display_area, hsync_in, vsync_in, mode_next,
      input  pixel_out, hsync_out, vsync_out, mode
   );

   modport slave (
      input  counter_x, counter_y, in_display_area, hsync_in, vsync_in, mode_next,
      output pixel_out, hsync_out, vsync_out, mode
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// Two-stage pixel pipeline: registers the beam position, then picks a 6-bit colour
// from one of four test patterns; pattern switches are deferred to frame boundaries.
//
//   state        | meaning
//   MODE_GRID    | 8x8 palette grid from position bits [8:6]
//   MODE_SCROLL  | horizontal gradient scrolled by the frame counter
//   MODE_CHECKER | 32-pixel checkerboard whose phase flips every 64 frames
//   MODE_WHITE   | solid white
module vga_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic          clk_25,
   input  logic          rst_n,
   vga_pattern_if.slave  vid
);

   typedef enum logic [1:0] {
      MODE_GRID    = 2'd0,
      MODE_SCROLL  = 2'd1,
      MODE_CHECKER = 2'd2,
      MODE_WHITE   = 2'd3
   } mode_e;

   // Geometry only matters to whoever drives the counters; nothing here depends on it.
   localparam logic unused_geometry = (H_ACTIVE > 0) && (V_ACTIVE > 0);

   logic [9:0] x_s1_q, y_s1_q;
   logic       de_s1_q, hs_s1_q, vs_s1_q;
   logic       vsync_prev_q;
   logic [7:0] frame_count_q, frame_count_d;
   logic       pending_q, pending_d;
   mode_e      mode_q, mode_d;
   logic [5:0] pixel_q, pixel_d;
   logic       hs_q, vs_q;
   logic       frame_edge;
   logic       unused_s1_bits;

   assign unused_s1_bits = ^{x_s1_q[3:0], y_s1_q[9], y_s1_q[4:0]};

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         x_s1_q        <= '0;
         y_s1_q        <= '0;
         de_s1_q       <= 1'b0;
         hs_s1_q       <= 1'b1;
         vs_s1_q       <= 1'b1;
         vsync_prev_q  <= 1'b1;
         frame_count_q <= '0;
         pending_q     <= 1'b0;
         mode_q        <= MODE_GRID;
         pixel_q       <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
      end else begin
         x_s1_q        <= vid.counter_x;
         y_s1_q        <= vid.counter_y;
         de_s1_q       <= vid.in_display_area;
         hs_s1_q       <= vid.hsync_in;
         vs_s1_q       <= vid.vsync_in;
         vsync_prev_q  <= vid.vsync_in;
         frame_count_q <= frame_count_d;
         pending_q     <= pending_d;
         mode_q        <= mode_d;
         pixel_q       <= pixel_d;
         hs_q          <= hs_s1_q;
         vs_q          <= vs_s1_q;
      end
   end

   // Edge is taken on the raw vsync so mode updates land during blanking.
   always_comb begin
      frame_edge    = vsync_prev_q & ~vid.vsync_in;
      frame_count_d = frame_count_q;
      pending_d     = pending_q;
      mode_d        = mode_q;
      if (frame_edge) begin
         frame_count_d = frame_count_q + 8'd1;
         if (pending_q) begin
            mode_d    = mode_e'(mode_q + 2'd1);
            pending_d = 1'b0;
         end
      end
      if (vid.mode_next) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      pixel_d = 6'h00;
      if (de_s1_q) begin
         case (mode_q)
            MODE_GRID:    pixel_d = {y_s1_q[8:6], x_s1_q[8:6]};
            MODE_SCROLL:  pixel_d = x_s1_q[9:4] + frame_count_q[5:0];
            MODE_CHECKER: pixel_d = (x_s1_q[5] ^ y_s1_q[5] ^ frame_count_q[6]) ? 6'h3F : 6'h00;
            default:      pixel_d = 6'h3F;
         endcase
      end
   end

   assign vid.pixel_out = pixel_q;
   assign vid.hsync_out = hs_q;
   assign vid.vsync_out = vs_q;
   assign vid.mode      = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset, pipeline alignment, the four patterns,
// frame-boundary mode switching and frame counter wrap.
module tb_vga_pattern_gen;

   logic clk_25 = 1'b0;
   logic rst_n  = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   fc      = 0;

   vga_pattern_if vif();

   vga_pattern_gen #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .vid    (vif.slave)
   );

   always #20 clk_25 = ~clk_25;

   task automatic tick();
      @(posedge clk_25);
      #1;
   endtask

   task automatic idle();
      vif.counter_x       = 10'd0;
      vif.counter_y       = 10'd0;
      vif.in_display_area = 1'b0;
      vif.hsync_in        = 1'b1;
      vif.vsync_in        = 1'b1;
      vif.mode_next       = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      fc = 0;
   endtask

   task automatic frame_edge(input bit req);
      vif.vsync_in  = 1'b0;
      vif.mode_next = req;
      tick();
      vif.vsync_in  = 1'b1;
      vif.mode_next = 1'b0;
      tick();
      fc = (fc + 1) % 256;
   endtask

   task automatic request();
      vif.mode_next = 1'b1;
      tick();
      vif.mode_next = 1'b0;
      tick();
   endtask

   task automatic sample_pix(input logic [9:0] x, input logic [9:0] y, input logic de,
                             output logic [5:0] p);
      vif.counter_x       = x;
      vif.counter_y       = y;
      vif.in_display_area = de;
      tick();
      tick();
      p = vif.pixel_out;
   endtask

   task automatic test_reset();
      do_reset();
      request();
      vif.counter_x       = 10'd200;
      vif.counter_y       = 10'd130;
      vif.in_display_area = 1'b1;
      vif.hsync_in        = 1'b0;
      tick();
      tick();
      n_tests++;
      if (vif.pixel_out !== 6'b010011 || vif.hsync_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pre: pixel=%h hs=%b, expected pixel=13 hs=0", vif.pixel_out, vif.hsync_out);
      end
      #5 rst_n = 1'b0;
      #1;
      n_tests++;
      if (vif.pixel_out !== 6'h00 || vif.hsync_out !== 1'b1 || vif.vsync_out !== 1'b1 || vif.mode !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_async: pixel=%h hs=%b vs=%b mode=%0d, expected 00 1 1 0",
                  vif.pixel_out, vif.hsync_out, vif.vsync_out, vif.mode);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (vif.pixel_out !== 6'h00) begin
         n_fail++;
         $display("FAIL reset_release_1: pixel=%h expected 00", vif.pixel_out);
      end
      tick();
      n_tests++;
      if (vif.pixel_out !== 6'b010011 || vif.hsync_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_2: pixel=%h hs=%b expected 13 0", vif.pixel_out, vif.hsync_out);
      end
      idle();
      fc = 0;
      frame_edge(1'b0);
      n_tests++;
      if (vif.mode !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_drops_pending: mode=%0d expected 0", vif.mode);
      end
   endtask

   task automatic test_mode0();
      logic [9:0] xs [4] = '{10'd200, 10'd639, 10'd64, 10'd200};
      logic [9:0] ys [4] = '{10'd130, 10'd479, 10'd64, 10'd130};
      logic       des[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [5:0] exp[4] = '{6'b010011, 6'h39, 6'h09, 6'h00};
      logic [5:0] p;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         sample_pix(xs[i], ys[i], des[i], p);
         n_tests++;
         if (p !== exp[i]) begin
            n_fail++;
            $display("FAIL mode0_vec%0d: pixel=%h expected %h", i, p, exp[i]);
         end
      end
      idle();
   endtask

   task automatic test_alignment();
      logic       p_de, p_hs, p_vs;
      logic [5:0] p_pix;
      bit         valid;
      int         y, shown;
      do_reset();
      valid = 0;
      shown = 0;
      p_de = 0; p_hs = 1; p_vs = 1; p_pix = 0;
      for (int ln = 0; ln < 51; ln++) begin
         y = (ln < 2) ? ln : 474 + ln;
         for (int x = 0; x < 800; x++) begin
            vif.counter_x       = 10'(x);
            vif.counter_y       = 10'(y);
            vif.in_display_area = (x < 640) && (y < 480);
            vif.hsync_in        = !(x >= 656 && x < 752);
            vif.vsync_in        = !(y == 490 || y == 491);
            tick();
            if (valid) begin
               n_tests++;
               if (vif.hsync_out !== p_hs || vif.vsync_out !== p_vs ||
                   vif.pixel_out !== (p_de ? p_pix : 6'h00)) begin
                  n_fail++;
                  if (shown < 10) begin
                     shown++;
                     $display("FAIL align y=%0d x=%0d: hs=%b vs=%b pix=%h expected %b %b %h",
                              y, x, vif.hsync_out, vif.vsync_out, vif.pixel_out,
                              p_hs, p_vs, p_de ? p_pix : 6'h00);
                  end
               end
            end
            p_de  = vif.in_display_area;
            p_hs  = vif.hsync_in;
            p_vs  = vif.vsync_in;
            p_pix = {vif.counter_y[8:6], vif.counter_x[8:6]};
            valid = 1;
         end
      end
      n_tests++;
      if (vif.mode !== 2'd0) begin
         n_fail++;
         $display("FAIL align_mode: mode=%0d expected 0", vif.mode);
      end
      idle();
   endtask

   task automatic test_mode_advance();
      do_reset();
      request();
      request();
      request();
      tick();
      n_tests++;
      if (vif.mode !== 2'd0) begin
         n_fail++;
         $display("FAIL adv_before_edge: mode=%0d expected 0", vif.mode);
      end
      frame_edge(1'b0);
      n_tests++;
      if (vif.mode !== 2'd1) begin
         n_fail++;
         $display("FAIL adv_collapse: mode=%0d expected 1", vif.mode);
      end
      frame_edge(1'b1);
      n_tests++;
      if (vif.mode !== 2'd1) begin
         n_fail++;
         $display("FAIL adv_same_cycle: mode=%0d expected 1", vif.mode);
      end
      frame_edge(1'b0);
      n_tests++;
      if (vif.mode !== 2'd2) begin
         n_fail++;
         $display("FAIL adv_next_edge: mode=%0d expected 2", vif.mode);
      end
      frame_edge(1'b0);
      n_tests++;
      if (vif.mode !== 2'd2) begin
         n_fail++;
         $display("FAIL adv_cleared: mode=%0d expected 2", vif.mode);
      end
   endtask

   task automatic test_scroll_wrap();
      logic [5:0] p;
      do_reset();
      request();
      frame_edge(1'b0);
      n_tests++;
      if (vif.mode !== 2'd1) begin
         n_fail++;
         $display("FAIL scroll_mode: mode=%0d expected 1", vif.mode);
      end
      while (fc < 70) frame_edge(1'b0);
      sample_pix(10'd16, 10'd100, 1'b1, p);
      n_tests++;
      if (p !== 6'd7) begin
         n_fail++;
         $display("FAIL scroll_70_x16: pixel=%0d expected 7", p);
      end
      sample_pix(10'd600, 10'd100, 1'b1, p);
      n_tests++;
      if (p !== 6'd43) begin
         n_fail++;
         $display("FAIL scroll_70_x600: pixel=%0d expected 43", p);
      end
      while (fc < 255) frame_edge(1'b0);
      sample_pix(10'd32, 10'd100, 1'b1, p);
      n_tests++;
      if (p !== 6'd1) begin
         n_fail++;
         $display("FAIL scroll_255_x32: pixel=%0d expected 1", p);
      end
      frame_edge(1'b0);
      sample_pix(10'd16, 10'd100, 1'b1, p);
      n_tests++;
      if (p !== 6'd1) begin
         n_fail++;
         $display("FAIL scroll_wrap_x16: pixel=%0d expected 1", p);
      end
      request();
      frame_edge(1'b0);
      n_tests++;
      if (vif.mode !== 2'd2) begin
         n_fail++;
         $display("FAIL checker_mode: mode=%0d expected 2", vif.mode);
      end
      sample_pix(10'd0, 10'd0, 1'b1, p);
      n_tests++;
      if (p !== 6'h00) begin
         n_fail++;
         $display("FAIL checker_fc1_00: pixel=%h expected 00", p);
      end
      sample_pix(10'd32, 10'd0, 1'b1, p);
      n_tests++;
      if (p !== 6'h3F) begin
         n_fail++;
         $display("FAIL checker_fc1_32: pixel=%h expected 3f", p);
      end
      while (fc < 64) frame_edge(1'b0);
      sample_pix(10'd0, 10'd0, 1'b1, p);
      n_tests++;
      if (p !== 6'h3F) begin
         n_fail++;
         $display("FAIL checker_fc64_00: pixel=%h expected 3f", p);
      end
      sample_pix(10'd32, 10'd32, 1'b1, p);
      n_tests++;
      if (p !== 6'h3F) begin
         n_fail++;
         $display("FAIL checker_fc64_3232: pixel=%h expected 3f", p);
      end
      idle();
   endtask

   task automatic test_mode_wrap();
      logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      logic [9:0] wx  [3] = '{10'd0, 10'd333, 10'd639};
      logic [9:0] wy  [3] = '{10'd0, 10'd250, 10'd479};
      logic [5:0] p;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         request();
         frame_edge(1'b0);
         n_tests++;
         if (vif.mode !== seq[i]) begin
            n_fail++;
            $display("FAIL wrap_step%0d: mode=%0d expected %0d", i, vif.mode, seq[i]);
         end
         if (seq[i] == 2'd3) begin
            for (int k = 0; k < 3; k++) begin
               sample_pix(wx[k], wy[k], 1'b1, p);
               n_tests++;
               if (p !== 6'h3F) begin
                  n_fail++;
                  $display("FAIL white_%0d: pixel=%h expected 3f", k, p);
               end
            end
            sample_pix(10'd700, 10'd10, 1'b0, p);
            n_tests++;
            if (p !== 6'h00) begin
               n_fail++;
               $display("FAIL white_blank: pixel=%h expected 00", p);
            end
            idle();
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_mode0();
      test_mode_advance();
      test_scroll_wrap();
      test_mode_wrap();
      test_alignment();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
